// File: rtl/rgb_window_3x3_if.sv
// rgb_window_3x3_if
//   Raster pixel stream feeding the 3x3 window generator.
//   in_valid : source has a pixel
//   in_ready : sink can take it (transfer on in_valid & in_ready)
//   in_sof   : accepted pixel is (0,0) of a new frame
//   in_R/G/B : pixel channels, DATA_W bits each
//   master = pixel source, slave = window generator.
interface rgb_window_3x3_if #(
  parameter int DATA_W = 8
);
  logic              in_valid;
  logic              in_ready;
  logic              in_sof;
  logic [DATA_W-1:0] in_R;
  logic [DATA_W-1:0] in_G;
  logic [DATA_W-1:0] in_B;

  modport master (output in_valid, in_sof, in_R, in_G, in_B, input in_ready);
  modport slave  (input in_valid, in_sof, in_R, in_G, in_B, output in_ready);
endinterface

// File: rtl/rgb_window_3x3.sv
// rgb_window_3x3
//   Streaming replicate-padded 3x3 neighbourhood generator. Buffers two lines
//   of RGB pixels and emits one window per image pixel; after the last input
//   pixel the final row is drained internally so each frame yields exactly
//   IMG_W*IMG_H windows.
// Ports
//   clk            : clock, rising edge
//   rst            : asynchronous active-low reset
//   pix            : slave side of the pixel stream (valid/ready/sof/R/G/B)
//   out_valid      : window registers updated this cycle
//   out_sof        : window centred on (0,0)
//   out_eof        : window centred on (IMG_W-1, IMG_H-1)
//   Reg_{R,G,B}k   : window taps, k = 3*(dy+1)+(dx+1), k=4 is the centre
module rgb_window_3x3 #(
  parameter int IMG_W  = 320,
  parameter int IMG_H  = 240,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  rgb_window_3x3_if.slave   pix,
  output logic              out_valid,
  output logic              out_sof,
  output logic              out_eof,
  output logic [DATA_W-1:0] Reg_R0, Reg_R1, Reg_R2, Reg_R3, Reg_R4,
  output logic [DATA_W-1:0] Reg_R5, Reg_R6, Reg_R7, Reg_R8,
  output logic [DATA_W-1:0] Reg_G0, Reg_G1, Reg_G2, Reg_G3, Reg_G4,
  output logic [DATA_W-1:0] Reg_G5, Reg_G6, Reg_G7, Reg_G8,
  output logic [DATA_W-1:0] Reg_B0, Reg_B1, Reg_B2, Reg_B3, Reg_B4,
  output logic [DATA_W-1:0] Reg_B5, Reg_B6, Reg_B7, Reg_B8
);

  localparam int AW = $clog2(IMG_W);
  localparam int XW = $clog2(IMG_W + 1);
  localparam int YW = $clog2(IMG_H + 1);
  localparam logic [XW-1:0] X_ONE  = XW'(1);
  localparam logic [XW-1:0] X_LAST = XW'(IMG_W - 1);
  localparam logic [XW-1:0] X_END  = XW'(IMG_W);
  localparam logic [YW-1:0] Y_ONE  = YW'(1);
  localparam logic [YW-1:0] Y_LAST = YW'(IMG_H - 1);

  typedef struct packed {
    logic [DATA_W-1:0] r;
    logic [DATA_W-1:0] g;
    logic [DATA_W-1:0] b;
  } pix_t;

  // One image column of the window: rows y-1, y, y+1.
  typedef struct packed {
    pix_t top;
    pix_t mid;
    pix_t bot;
  } col_t;

  typedef enum logic [1:0] {IDLE, FILL, RUN, FLUSH} state_t;

  state_t        state, state_nxt;
  // px/py: position of the next pixel to be accepted; in FLUSH px walks the
  // virtual column index 0..IMG_W of the drained row.
  logic [XW-1:0] px;
  logic [YW-1:0] py;

  pix_t lb1 [IMG_W];   // previous line
  pix_t lb2 [IMG_W];   // line before that
  col_t sr0, sr1;      // most recent and second most recent columns

  logic          accept, take;
  logic [AW-1:0] wr_idx, rd_idx;
  pix_t          in_pix, lb_top, lb_mid;
  col_t          new_col, col_l, col_c, col_r;
  pix_t          win_p0 [9];
  logic          vld_p0, sof_p0, eof_p0;
  pix_t          win_p1 [9];
  logic          vld_p1, sof_p1, eof_p1;

  assign pix.in_ready = rst & (state != FLUSH);
  assign accept       = pix.in_valid & pix.in_ready;
  // Outside a frame only an in_sof pixel is kept; others are swallowed.
  assign take         = accept & ((state != IDLE) | pix.in_sof);
  assign in_pix       = {pix.in_R, pix.in_G, pix.in_B};
  assign wr_idx       = pix.in_sof ? '0 : AW'(px);
  assign rd_idx       = (px == X_END) ? '0 : AW'(px);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:  if (take) state_nxt = FILL;
      FILL:  if (take) begin
               if (pix.in_sof)                    state_nxt = FILL;
               else if (px == '0 && py == Y_ONE)  state_nxt = RUN;
             end
      RUN:   if (take) begin
               if (pix.in_sof)                         state_nxt = FILL;
               else if (px == X_LAST && py == Y_LAST)  state_nxt = FLUSH;
             end
      FLUSH: if (px == X_END) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Column assembly and horizontal edge replication.
  always_comb begin
    lb_top = lb2[rd_idx];
    lb_mid = lb1[rd_idx];
    if (state == FLUSH)
      new_col = {lb_top, lb_mid, lb_mid};            // bottom row replicated
    else if (py == Y_ONE)
      new_col = {lb_mid, lb_mid, in_pix};            // top row replicated
    else
      new_col = {lb_top, lb_mid, in_pix};

    // px==0 (or the drain tail) closes the previous line: right column
    // replicates the centre. px==1 opens a line: left replicates the centre.
    col_l = sr1;
    col_c = sr0;
    col_r = new_col;
    if (px == '0 || px == X_END) begin
      col_r = sr0;
    end else if (px == X_ONE) begin
      col_l = sr0;
    end

    win_p0[0] = col_l.top; win_p0[1] = col_c.top; win_p0[2] = col_r.top;
    win_p0[3] = col_l.mid; win_p0[4] = col_c.mid; win_p0[5] = col_r.mid;
    win_p0[6] = col_l.bot; win_p0[7] = col_c.bot; win_p0[8] = col_r.bot;

    vld_p0 = (state == RUN && take && !pix.in_sof) || (state == FLUSH);
    sof_p0 = state == RUN && take && !pix.in_sof && px == X_ONE && py == Y_ONE;
    eof_p0 = state == FLUSH && px == X_END;
  end

  // ---- stage p0 -> p1: control, counters and window registers ----
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= IDLE;
      px     <= '0;
      py     <= '0;
      vld_p1 <= 1'b0;
      sof_p1 <= 1'b0;
      eof_p1 <= 1'b0;
      for (int k = 0; k < 9; k++) win_p1[k] <= '0;
    end else begin
      state  <= state_nxt;
      vld_p1 <= vld_p0;
      sof_p1 <= sof_p0;
      eof_p1 <= eof_p0;
      if (vld_p0) begin
        for (int k = 0; k < 9; k++) win_p1[k] <= win_p0[k];
      end
      if (take) begin
        if (pix.in_sof) begin
          px <= X_ONE;
          py <= '0;
        end else if (px == X_LAST) begin
          px <= '0;
          py <= (py == Y_LAST) ? '0 : py + Y_ONE;
        end else begin
          px <= px + X_ONE;
        end
      end else if (state == FLUSH) begin
        px <= (px == X_END) ? '0 : px + X_ONE;
      end
    end
  end

  // Line buffers and column shift registers carry no reset; nothing is
  // emitted from them until the current frame has overwritten them.
  always_ff @(posedge clk) begin
    if (take) begin
      lb1[wr_idx] <= in_pix;
      lb2[wr_idx] <= lb1[wr_idx];
    end
    if (take || state == FLUSH) begin
      sr1 <= sr0;
      sr0 <= new_col;
    end
  end

  assign out_valid = vld_p1;
  assign out_sof   = sof_p1;
  assign out_eof   = eof_p1;

  assign Reg_R0 = win_p1[0].r; assign Reg_G0 = win_p1[0].g; assign Reg_B0 = win_p1[0].b;
  assign Reg_R1 = win_p1[1].r; assign Reg_G1 = win_p1[1].g; assign Reg_B1 = win_p1[1].b;
  assign Reg_R2 = win_p1[2].r; assign Reg_G2 = win_p1[2].g; assign Reg_B2 = win_p1[2].b;
  assign Reg_R3 = win_p1[3].r; assign Reg_G3 = win_p1[3].g; assign Reg_B3 = win_p1[3].b;
  assign Reg_R4 = win_p1[4].r; assign Reg_G4 = win_p1[4].g; assign Reg_B4 = win_p1[4].b;
  assign Reg_R5 = win_p1[5].r; assign Reg_G5 = win_p1[5].g; assign Reg_B5 = win_p1[5].b;
  assign Reg_R6 = win_p1[6].r; assign Reg_G6 = win_p1[6].g; assign Reg_B6 = win_p1[6].b;
  assign Reg_R7 = win_p1[7].r; assign Reg_G7 = win_p1[7].g; assign Reg_B7 = win_p1[7].b;
  assign Reg_R8 = win_p1[8].r; assign Reg_G8 = win_p1[8].g; assign Reg_B8 = win_p1[8].b;

endmodule

// File: tb/tb_rgb_window_3x3.sv
// tb_rgb_window_3x3
//   Directed bench for rgb_window_3x3 with a 4x3 image. Pixel i of a frame is
//   R=i, G=100+i, B=200+i. Every window is compared with a clamp-based
//   neighbourhood model, with hand-computed spot values for selected centres.
module tb_rgb_window_3x3;

  localparam int IMG_W = 4;
  localparam int IMG_H = 3;
  localparam int NPIX  = IMG_W * IMG_H;
  localparam int VW    = 216;

  logic clk;
  logic rst;
  logic out_valid, out_sof, out_eof;
  logic [7:0] Reg_R0, Reg_R1, Reg_R2, Reg_R3, Reg_R4, Reg_R5, Reg_R6, Reg_R7, Reg_R8;
  logic [7:0] Reg_G0, Reg_G1, Reg_G2, Reg_G3, Reg_G4, Reg_G5, Reg_G6, Reg_G7, Reg_G8;
  logic [7:0] Reg_B0, Reg_B1, Reg_B2, Reg_B3, Reg_B4, Reg_B5, Reg_B6, Reg_B7, Reg_B8;
  logic [VW-1:0] obs;
  logic [71:0]   spec_v;

  int checks = 0;
  int errors = 0;
  int wcnt   = 0;

  rgb_window_3x3_if #(.DATA_W(8)) pix_if ();

  rgb_window_3x3 #(.IMG_W(IMG_W), .IMG_H(IMG_H), .DATA_W(8)) dut (
    .clk(clk), .rst(rst), .pix(pix_if.slave),
    .out_valid(out_valid), .out_sof(out_sof), .out_eof(out_eof),
    .Reg_R0(Reg_R0), .Reg_R1(Reg_R1), .Reg_R2(Reg_R2), .Reg_R3(Reg_R3), .Reg_R4(Reg_R4),
    .Reg_R5(Reg_R5), .Reg_R6(Reg_R6), .Reg_R7(Reg_R7), .Reg_R8(Reg_R8),
    .Reg_G0(Reg_G0), .Reg_G1(Reg_G1), .Reg_G2(Reg_G2), .Reg_G3(Reg_G3), .Reg_G4(Reg_G4),
    .Reg_G5(Reg_G5), .Reg_G6(Reg_G6), .Reg_G7(Reg_G7), .Reg_G8(Reg_G8),
    .Reg_B0(Reg_B0), .Reg_B1(Reg_B1), .Reg_B2(Reg_B2), .Reg_B3(Reg_B3), .Reg_B4(Reg_B4),
    .Reg_B5(Reg_B5), .Reg_B6(Reg_B6), .Reg_B7(Reg_B7), .Reg_B8(Reg_B8)
  );

  assign obs = {Reg_R0, Reg_R1, Reg_R2, Reg_R3, Reg_R4, Reg_R5, Reg_R6, Reg_R7, Reg_R8,
                Reg_G0, Reg_G1, Reg_G2, Reg_G3, Reg_G4, Reg_G5, Reg_G6, Reg_G7, Reg_G8,
                Reg_B0, Reg_B1, Reg_B2, Reg_B3, Reg_B4, Reg_B5, Reg_B6, Reg_B7, Reg_B8};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [VW-1:0] got, input logic [VW-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Expected window for centre index c of the raster pattern frame.
  function automatic logic [VW-1:0] exp_win(input int c);
    logic [VW-1:0] res;
    int x, y, xx, yy;
    res = '0;
    x = c % IMG_W;
    y = c / IMG_W;
    for (int ch = 0; ch < 3; ch++) begin
      for (int k = 0; k < 9; k++) begin
        xx = x + (k % 3) - 1;
        yy = y + (k / 3) - 1;
        if (xx < 0) xx = 0;
        if (xx > IMG_W - 1) xx = IMG_W - 1;
        if (yy < 0) yy = 0;
        if (yy > IMG_H - 1) yy = IMG_H - 1;
        res = {res[VW-9:0], 8'(yy * IMG_W + xx + 100 * ch)};
      end
    end
    return res;
  endfunction

  // Window monitor: the n-th window of a frame must be centre n.
  always @(negedge clk) begin
    if (out_valid) begin
      if (wcnt >= NPIX) begin
        chk("extra_win", VW'(wcnt), VW'(NPIX - 1));
      end else begin
        chk("window", obs, exp_win(wcnt));
        chk("sof", VW'(out_sof), VW'(wcnt == 0));
        chk("eof", VW'(out_eof), VW'(wcnt == NPIX - 1));
        if (wcnt == 0) begin
          spec_v = {8'd0, 8'd0, 8'd1, 8'd0, 8'd0, 8'd1, 8'd4, 8'd4, 8'd5};
          chk("spec_first_R", VW'(obs[VW-1 -: 72]), VW'(spec_v));
        end else if (wcnt == 7) begin
          spec_v = {8'd2, 8'd3, 8'd3, 8'd6, 8'd7, 8'd7, 8'd10, 8'd11, 8'd11};
          chk("spec_x3y1_R", VW'(obs[VW-1 -: 72]), VW'(spec_v));
        end else if (wcnt == NPIX - 1) begin
          spec_v = {8'd6, 8'd7, 8'd7, 8'd10, 8'd11, 8'd11, 8'd10, 8'd11, 8'd11};
          chk("spec_last_R", VW'(obs[VW-1 -: 72]), VW'(spec_v));
          spec_v = {8'd106, 8'd107, 8'd107, 8'd110, 8'd111, 8'd111, 8'd110, 8'd111, 8'd111};
          chk("spec_last_G", VW'(obs[VW-73 -: 72]), VW'(spec_v));
        end
      end
      wcnt++;
    end else if (out_sof || out_eof) begin
      chk("pulse_no_valid", VW'({out_sof, out_eof}), VW'(0));
    end
  end

  task automatic send_px(input int v, input bit sof, input int gap);
    bit rdy;
    int n;
    repeat (gap) begin
      pix_if.in_valid = 1'b0;
      @(posedge clk); #1;
    end
    pix_if.in_valid = 1'b1;
    pix_if.in_sof   = sof;
    pix_if.in_R     = 8'(v);
    pix_if.in_G     = 8'(v + 100);
    pix_if.in_B     = 8'(v + 200);
    n = 0;
    do begin
      rdy = pix_if.in_ready;
      @(posedge clk); #1;
      n++;
    end while (!rdy && n < 50);
    if (!rdy) chk("accept_timeout", VW'(0), VW'(1));
    pix_if.in_valid = 1'b0;
    pix_if.in_sof   = 1'b0;
  endtask

  // Sends one pattern frame and checks the drain phase and window count.
  task automatic run_frame(input int gapmax);
    wcnt = 0;
    for (int i = 0; i < NPIX; i++)
      send_px(i, i == 0, (gapmax > 0) ? int'($urandom_range(0, gapmax)) : 0);
    chk("flush_rdy_first", VW'(pix_if.in_ready), VW'(0));
    @(negedge clk); #1;
    chk("preflush_windows", VW'(wcnt), VW'(7));
    for (int i = 0; i <= IMG_W; i++) begin
      @(posedge clk); #1;
      chk("flush_valid", VW'(out_valid), VW'(1));
      chk("flush_rdy", VW'(pix_if.in_ready), VW'(i == IMG_W));
    end
    @(posedge clk); #1;
    chk("post_flush_valid", VW'(out_valid), VW'(0));
    repeat (3) @(posedge clk);
    #1;
    chk("frame_windows", VW'(wcnt), VW'(NPIX));
  endtask

  initial begin
    rst = 1'b0;
    pix_if.in_valid = 1'b0;
    pix_if.in_sof   = 1'b0;
    pix_if.in_R = '0; pix_if.in_G = '0; pix_if.in_B = '0;
    #2;
    chk("rst_ready", VW'(pix_if.in_ready), VW'(0));
    chk("rst_valid", VW'({out_valid, out_sof, out_eof}), VW'(0));
    chk("rst_window", obs, VW'(0));
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b1;
    #1;
    chk("rel_ready", VW'(pix_if.in_ready), VW'(1));

    // Continuous frame
    run_frame(0);

    // Same frame with random input gaps
    run_frame(2);

    // Pixels before any in_sof are swallowed
    wcnt = 0;
    for (int i = 0; i < 3; i++) send_px(77, 1'b0, 0);
    repeat (3) @(posedge clk);
    #1;
    chk("pre_sof_windows", VW'(wcnt), VW'(0));
    run_frame(0);

    // Frame abandoned by in_sof on its 4th pixel
    wcnt = 0;
    for (int i = 0; i < 3; i++) send_px(50 + i, i == 0, 0);
    chk("abandon_windows", VW'(wcnt), VW'(0));
    run_frame(0);

    // Reset pulsed during the drain phase
    wcnt = 0;
    for (int i = 0; i < NPIX; i++) send_px(i, i == 0, 0);
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
    #1;
    chk("midrst_valid", VW'({out_valid, out_sof, out_eof}), VW'(0));
    chk("midrst_window", obs, VW'(0));
    chk("midrst_ready", VW'(pix_if.in_ready), VW'(0));
    @(posedge clk); #1;
    chk("midrst_ready_hold", VW'(pix_if.in_ready), VW'(0));
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("after_rst_idle", VW'(out_valid), VW'(0));
    run_frame(1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog_timeout got=running exp=finished");
    $fatal(1);
  end

endmodule

// File: doc/rgb_window_3x3.md
# rgb_window_3x3

Streaming 3x3 neighbourhood generator for the dehazing pipeline. It accepts a raster-order RGB pixel stream and buffers two image lines per channel in internal line memories. It emits, one per output, the replicate-padded 3x3 window around every pixel, and its outputs drive the 27 `Reg_R*`/`Reg_G*`/`Reg_B*` inputs of the atmospheric-light stage directly. After the last input pixel it drains the final row on its own, so every frame produces exactly IMG_W*IMG_H windows.

## Interface
- `IMG_W`, 320, pixels per line (≥ 3)
- `IMG_H`, 240, lines per frame (≥ 3)
- `clk`  in  1  single clock; all state on rising edge
- `rst`  in  1  asynchronous, active-low reset
- `in_valid`  in  1  input pixel present
- `in_ready`  out  1  block can accept; a pixel transfers when `in_valid & in_ready`
- `in_sof`  in  1  qualifies the accepted pixel as (0,0) of a new frame
- `in_R`, `in_G`, `in_B`  in  8 each  input pixel channels
- `out_valid`  out  1  window outputs valid this cycle (no backpressure)
- `out_sof`  out  1  with `out_valid`: window centred on (0,0)
- `out_eof`  out  1  with `out_valid`: window centred on (IMG_W-1, IMG_H-1)
- `Reg_R0`..`Reg_R8`, `Reg_G0`..`Reg_G8`, `Reg_B0`..`Reg_B8`  out  8 each  window; index k = 3*(dy+1)+(dx+1), dy,dx ∈ {-1,0,1}; k=0 top-left, k=4 centre, k=8 bottom-right

## Operation
- Window content for centre (x,y): `Reg_Ck = P_C(clamp(x+dx,0,IMG_W-1), clamp(y+dy,0,IMG_H-1))` (edge replication).
- Two line buffers of IMG_W x 24 bits plus column shift registers. RAM or register implementation is free, provided the behaviour below is met.
- Pixel counter p (0..IMG_W*IMG_H-1) advances on each accepted pixel. The window for centre index c = p-(IMG_W+1) is produced when pixel p is accepted.
- State machine:
  - IDLE: wait for an accepted pixel with `in_sof`=1. Pixels without `in_sof` are accepted and dropped. Go to FILL with p=0.
  - FILL: accept pixels with no output. After accepting p = IMG_W, go to RUN.
  - RUN: each accepted pixel produces one window. When the accepted pixel is p = IMG_W*IMG_H-1, go to FLUSH.
  - FLUSH: `in_ready`=0. Emit the remaining IMG_W+1 windows (centres IMG_W*IMG_H-IMG_W-1 .. IMG_W*IMG_H-1), one per cycle and back-to-back. The last one carries `out_eof`. Then go to IDLE.
- `in_sof` on an accepted pixel in FILL or RUN abandons the current frame: no further windows are emitted for it, no `out_eof` is generated, and the accepted pixel becomes (0,0) of a new frame in FILL.
- `in_ready` = 1 in IDLE, FILL and RUN, 0 in FLUSH and while `rst` is low. It is a combinational function of state.
- No arithmetic on pixel data; values are passed bit-exact.

## Timing
- Reset (async assert, sync release): state IDLE, counters 0. `out_valid`, `out_sof`, `out_eof` and all 27 `Reg_*` outputs are 0. Line-buffer contents are don't-care, and no window is ever emitted that depends on stale data.
- Output latency: registered outputs appear the cycle after the acceptance of pixel c+IMG_W+1 (RUN) or the FLUSH cycle.
- `in_valid` gaps in RUN produce matching `out_valid` gaps. Window outputs hold their last value when `out_valid`=0.
- First FLUSH cycle: `in_ready`=0 in the cycle immediately after the last pixel is accepted. FLUSH lasts exactly IMG_W+1 cycles. `in_ready` returns to 1 in the cycle after the final FLUSH output edge.
- `out_sof`/`out_eof` are single-cycle pulses, only with `out_valid`=1.
- Reset asserted mid-frame or mid-FLUSH: outputs clear immediately. After release the block behaves as freshly reset.

## Test plan
Use IMG_W=4, IMG_H=3 and pixel i (raster) = R i, G 100+i, B 200+i.
- Continuous frame, `in_valid`=1 throughout, `in_sof` on pixel 0 -> first `out_valid` the cycle after pixel 5 is accepted, with `out_sof`=1 and R0..R8 = 0,0,1,0,0,1,4,4,5 (G = +100, B = +200). Exactly 12 windows total.
- Same frame, end of frame -> after pixel 11 is accepted, `in_ready`=0 for exactly 5 cycles with 5 consecutive windows. The last has `out_eof`=1 and R0..R8 = 6,7,7,10,11,11,10,11,11. Centre x=3,y=1 window is R 2,3,3,6,7,7,10,11,11.
- Random `in_valid` gaps -> identical window sequence to the continuous case. `out_valid` count before FLUSH = 7.
- `in_sof` re-asserted on the 4th pixel of a frame -> no windows or `out_eof` for the old frame. The new frame yields 12 correct windows measured from the new (0,0).
- Pixels sent before any `in_sof` -> accepted (`in_ready`=1), no output. Then a normal frame produces correct results.
- `rst` pulsed low during FLUSH -> all outputs 0 immediately and `in_ready`=0 during reset. The next full frame is correct with no leftover windows.
